// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo family and its stream readers.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SKID_DEPTH     = 2;

    typedef logic [1:0] occ_t;

    // Occupancy after one cycle of capture and pop; the issue rule keeps this within 0..SKID_DEPTH.
    function automatic occ_t next_occ(input occ_t occ, input logic capture, input logic pop);
        return occ + {1'b0, capture} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry ping-pong buffer that absorbs the FIFO read latency and feeds a valid/ready stream.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output occ_t                  occupancy
);

    logic [DATA_WIDTH-1:0] mem_r [SKID_DEPTH];
    logic                  wr_idx_r;
    logic                  rd_idx_r;
    occ_t                  occ_r;

    // Buffer storage, index and occupancy update; flush discards contents by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_idx_r <= 1'b0;
            rd_idx_r <= 1'b0;
            occ_r    <= 2'd0;
        end else if (flush) begin
            wr_idx_r <= 1'b0;
            rd_idx_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (capture) begin
                mem_r[wr_idx_r] <= in_data;
                wr_idx_r        <= ~wr_idx_r;
            end
            if (pop) begin
                rd_idx_r <= ~rd_idx_r;
            end
            occ_r <= next_occ(occ_r, capture, pop);
        end
    end

    assign out_valid = (occ_r != 2'd0) && !flush;
    assign out_data  = mem_r[rd_idx_r];
    assign occupancy = occ_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-output sync FIFO and presents its words as a valid/ready stream with flush
// and a delivered-word counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    logic                 inflight_r;
    logic [CNT_WIDTH-1:0] word_count_r;
    logic                 pop_out_s;
    logic                 rd_en_s;
    logic [2:0]           demand_s;
    occ_t                 occ_s;

    assign pop_out_s = m_valid && m_ready && !flush;

    // Pop issue: only request a word when the buffer has room for it after counting the one in flight.
    always_comb begin
        demand_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_out_s};
        rd_en_s  = 1'b0;
        if (rst || flush || fifo_empty) begin
            rd_en_s = 1'b0;
        end else if (demand_s < 3'd2) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    assign fifo_rd_en = rd_en_s;

    // Track the pop issued last cycle; a flush or reset drops the word that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
        end else if (flush) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_en_s;
        end
    end

    // Delivered-word counter, wraps naturally and ignores flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_r <= {CNT_WIDTH{1'b0}};
        end else if (pop_out_s) begin
            word_count_r <= word_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .capture   (inflight_r),
        .in_data   (fifo_rd_data),
        .pop       (pop_out_s),
        .out_valid (m_valid),
        .out_data  (m_data),
        .occupancy (occ_s)
    );

    assign occupancy  = occ_s;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural registered-output FIFO.
module tb_fifo_stream_reader;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        m_ready;
    logic        fifo_rd_en;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        m_valid;
    logic [7:0]  m_data;
    logic [1:0]  occupancy;
    logic [15:0] word_count;

    logic        fifo_clr;
    logic        push_en;
    logic [7:0]  push_data;
    logic [7:0]  fmem [8];
    logic [2:0]  head;
    logic [2:0]  tail;
    logic [3:0]  fcnt;

    logic        fifo_rd_en2;
    logic        fifo_empty2;
    logic [7:0]  fifo_rd_data2;
    logic        m_valid2;
    logic [7:0]  m_data2;
    logic        m_ready2;
    logic        flush2;
    logic [1:0]  occupancy2;
    logic [3:0]  word_count2;
    logic [7:0]  src_next;

    int total;
    int bad;

    fifo_stream_reader dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .flush        (flush),
        .occupancy    (occupancy),
        .word_count   (word_count)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en2),
        .fifo_empty   (fifo_empty2),
        .fifo_rd_data (fifo_rd_data2),
        .m_valid      (m_valid2),
        .m_data       (m_data2),
        .m_ready      (m_ready2),
        .flush        (flush2),
        .occupancy    (occupancy2),
        .word_count   (word_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Depth-8 FIFO with registered read data
    always @(posedge clk) begin
        if (fifo_clr) begin
            head         <= 3'd0;
            tail         <= 3'd0;
            fcnt         <= 4'd0;
            fifo_rd_data <= 8'h00;
        end else begin
            if (push_en) begin
                fmem[tail] <= push_data;
                tail       <= tail + 3'd1;
            end
            if (fifo_rd_en) begin
                fifo_rd_data <= fmem[head];
                head         <= head + 3'd1;
            end
            fcnt <= fcnt + 4'(push_en) - 4'(fifo_rd_en);
        end
    end
    assign fifo_empty = (fcnt == 4'd0);

    // Endless counting source for the narrow-counter instance
    always @(posedge clk) begin
        if (rst) begin
            src_next      <= 8'h00;
            fifo_rd_data2 <= 8'h00;
        end else if (fifo_rd_en2) begin
            fifo_rd_data2 <= src_next;
            src_next      <= src_next + 8'h01;
        end
    end
    assign fifo_empty2 = 1'b0;
    assign flush2      = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds rst, clears the FIFO model, preloads n words, then releases rst on a negedge.
    task automatic reset_and_load(input int n, input logic [7:0] base, input logic [7:0] step);
        rst      = 1'b1;
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = base + 8'(i) * step;
            @(negedge clk);
        end
        push_en = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        int wait_cyc;
        int pulses;
        int k;
        int cnt;
        logic [7:0] exp8;

        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        fifo_clr  = 1'b1;
        flush     = 1'b0;
        m_ready   = 1'b0;
        m_ready2  = 1'b0;
        push_en   = 1'b0;
        push_data = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'h00);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

        // Basic latency: 11,22,33
        m_ready = 1'b1;
        reset_and_load(3, 8'h11, 8'h11);
        #1;
        check("lat_rd_en", 32'(fifo_rd_en), 32'd1);
        check("lat_mv0", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("lat_mv1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("lat_mv2", 32'(m_valid), 32'd1);
        check("lat_d0", 32'(m_data), 32'h11);
        @(negedge clk);
        check("lat_d1", 32'(m_data), 32'h22);
        @(negedge clk);
        check("lat_d2", 32'(m_data), 32'h33);
        @(negedge clk);
        check("lat_idle", 32'(m_valid), 32'd0);
        check("lat_count", 32'(word_count), 32'd3);

        // Throughput: 8 preloaded words, no bubbles
        reset_and_load(8, 8'hA0, 8'h01);
        wait_cyc = 0;
        while (!m_valid && wait_cyc < 6) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("thr_latency", 32'(wait_cyc), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("thr_valid", 32'(m_valid), 32'd1);
            check("thr_data", 32'(m_data), 32'(8'hA0 + 8'(i)));
            @(negedge clk);
        end
        check("thr_end_valid", 32'(m_valid), 32'd0);
        check("thr_end_empty", 32'(fifo_empty), 32'd1);
        check("thr_count", 32'(word_count), 32'd8);

        // Backpressure: 5 words, m_ready low for 10 cycles
        m_ready = 1'b0;
        reset_and_load(5, 8'hB0, 8'h01);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            pulses += 32'(fifo_rd_en);
            @(negedge clk);
        end
        check("bp_pulses", 32'(pulses), 32'd2);
        check("bp_occ", 32'(occupancy), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_hold", 32'(m_data), 32'hB0);
        m_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            if (m_valid) begin
                check("bp_order", 32'(m_data), 32'(8'hB0 + 8'(k)));
                k++;
            end
            @(negedge clk);
        end
        check("bp_delivered", 32'(k), 32'd5);
        check("bp_count", 32'(word_count), 32'd5);

        // Flush with one word buffered and one in flight
        m_ready   = 1'b0;
        push_en   = 1'b1;
        push_data = 8'hC0;
        @(negedge clk);
        push_data = 8'hC1;
        #1;
        check("fl_rd_en_pre", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        push_data = 8'hC2;
        @(negedge clk);
        push_en = 1'b0;
        check("fl_occ_pre", 32'(occupancy), 32'd1);
        check("fl_head_pre", 32'(m_data), 32'hC0);
        flush = 1'b1;
        #1;
        check("fl_mv_during", 32'(m_valid), 32'd0);
        check("fl_rd_en_during", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_mv_after", 32'(m_valid), 32'd0);
        check("fl_occ_after", 32'(occupancy), 32'd0);
        check("fl_count_kept", 32'(word_count), 32'd5);
        m_ready  = 1'b1;
        wait_cyc = 0;
        while (!m_valid && wait_cyc < 6) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("fl_next_valid", 32'(m_valid), 32'd1);
        check("fl_next_data", 32'(m_data), 32'hC2);
        @(negedge clk);
        check("fl_next_idle", 32'(m_valid), 32'd0);
        check("fl_next_count", 32'(word_count), 32'd6);

        // Reset mid-stream
        reset_and_load(8, 8'hD0, 8'h01);
        repeat (5) @(negedge clk);
        check("mr_active", 32'(m_valid), 32'd1);
        rst      = 1'b1;
        fifo_clr = 1'b1;
        #1;
        check("mr_rd_en_in_rst", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        check("mr_valid", 32'(m_valid), 32'd0);
        check("mr_data", 32'(m_data), 32'h00);
        check("mr_occ", 32'(occupancy), 32'd0);
        check("mr_count", 32'(word_count), 32'd0);
        check("mr_rd_en", 32'(fifo_rd_en), 32'd0);
        rst      = 1'b0;
        fifo_clr = 1'b0;

        // Counter wrap on the 4-bit instance: 17 words
        cnt = 0;
        for (int c = 0; c < 80 && cnt < 17; c++) begin
            @(negedge clk);
            if (m_valid2) begin
                exp8 = cnt[7:0];
                check("wrap_data", 32'(m_data2), 32'(exp8));
                m_ready2 = 1'b1;
                cnt++;
            end else begin
                m_ready2 = 1'b0;
            end
        end
        @(negedge clk);
        m_ready2 = 1'b0;
        check("wrap_delivered", 32'(cnt), 32'd17);
        check("wrap_count", 32'(word_count2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Drains a synchronous FIFO through its rd_en/empty/rd_data pop interface and presents the words as a valid/ready stream.
- The FIFO's rd_data is registered, so it is valid one cycle after a pop.
- A 2-entry output buffer hides that latency and sustains one word per cycle under continuous m_ready.
- Sits between sync_fifo instances and downstream stream consumers; also provides a flush and a delivered-word counter.

Parameters:
- DATA_WIDTH, 8, width of each data word; must match the FIFO's DATA_WIDTH.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- fifo_rd_en  output  1  pop request to the FIFO; combinational.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after a pop.
- m_valid  output  1  output word available.
- m_data  output  DATA_WIDTH  output word (head of buffer).
- m_ready  input  1  downstream accepts m_data this cycle.
- flush  input  1  synchronous discard of buffered and in-flight words.
- occupancy  output  2  buffered words, 0..2.
- word_count  output  CNT_WIDTH  words delivered (m_valid && m_ready) since reset.

Behaviour:
- Internal state:
  - buf[0:1] with rd/wr index bits.
  - occ, 0..2.
  - inflight, 1 bit: a pop was issued last cycle.
  - word_count.
- pop_out = m_valid && m_ready && !flush.
- fifo_rd_en = !rst && !flush && !fifo_empty && (occ + inflight - pop_out) < 2.
  - fifo_rd_en is never asserted while fifo_empty=1, so every asserted pop is a real FIFO read.
  - inflight <= fifo_rd_en each cycle (0 on rst or flush).
- Capture: when inflight=1 and no flush this cycle, fifo_rd_data is written into buf[wr_idx], and wr_idx toggles.
- Output:
  - m_valid = (occ != 0) && !flush.
  - m_data = buf[rd_idx].
  - On pop_out, rd_idx toggles.
- occ next = occ + capture - pop_out. Simultaneous capture and pop keeps occ unchanged. occ never exceeds 2; overflow is impossible by the fifo_rd_en rule.
- Ordering: words leave in exact FIFO pop order; no reordering and no duplication.
- Stream rule: while m_valid=1 and m_ready=0, m_data is held stable and m_valid stays 1.
- Latency:
  - Empty to first m_valid: FIFO non-empty in cycle N → fifo_rd_en in N → m_valid in N+2 (data captured at end of N+1).
  - Steady state with m_ready=1 and a non-empty FIFO: 1 word/cycle.
- Backpressure with m_ready=0: at most 2 words are popped, then fifo_rd_en stays 0.
- flush (has priority over all other events):
  - In the flush cycle: m_valid=0, fifo_rd_en=0, no pop_out, no capture.
  - Next cycle: occ=0, indices=0, inflight=0.
  - A word popped the cycle before flush is discarded on arrival.
  - word_count is unaffected.
- word_count increments on each pop_out and wraps modulo 2^CNT_WIDTH.
- Reset (synchronous, active-high), effective next edge:
  - occ=0, inflight=0, indices=0, buf cleared to 0, word_count=0.
  - Outputs: m_valid=0, m_data=0, occupancy=0, word_count=0, fifo_rd_en=0 during rst.
  - Reset mid-transfer drops the in-flight word; the FIFO itself must be reset alongside.
- fifo_empty toggling: fifo_rd_en re-evaluates every cycle with no hysteresis.

Decomposition:
- Shared package fifo_pkg holds the DATA_WIDTH default and the SKID_DEPTH=2 constant; sync_fifo uses the same package.
- One natural sub-module: stream_skid_buf, the 2-entry buffer with occ/index logic and a capture/pop/flush interface. The top level holds the pop-issue logic and word_count.

Test Plan:
- Basic latency: sync_fifo holds 8'h11,8'h22,8'h33 at reset release, m_ready=1 → first m_valid 2 cycles after the first fifo_rd_en, then 11,22,33 on consecutive cycles; word_count=3.
- Throughput: 8 words preloaded (FIFO full), m_ready=1 constantly → 8 consecutive m_valid cycles with no bubbles after the first; fifo_empty=1 and m_valid=0 after.
- Backpressure: 5 words queued, m_ready=0 for 10 cycles → exactly 2 fifo_rd_en pulses, occupancy=2, m_data stable at word0; release m_ready → words 0..4 delivered in order.
- Flush with in-flight data: occ=1 and a pop issued the previous cycle, assert flush 1 cycle → m_valid=0 next cycle, the arriving word is not delivered, occupancy=0, word_count unchanged; the next FIFO word is delivered normally.
- Reset mid-stream: assert rst during continuous transfer → next cycle m_valid=0, m_data=0, occupancy=0, word_count=0, fifo_rd_en=0 while rst=1.
- Counter wrap: CNT_WIDTH=4, deliver 17 words → word_count reads 1.
